// File: rtl/buffer_sequencer.sv
// rtl/buffer_sequencer.sv - one load/drain pass sequencer for the N_BUF-bank activation buffer
module buffer_sequencer #(
    parameter int N_BUF       = 8,
    parameter int ADDR_RAM    = 10,
    parameter int WID_PE_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_RAM:0]           cfg_len,
    input  logic [$clog2(N_BUF):0]      cfg_banks,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WID_PE_BITS-1:0]      in_data,
    input  logic                        drain_ready,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        mode,
    output logic [N_BUF-1:0]            m0_w_en,
    output logic [ADDR_RAM-1:0]         m0_w_addr,
    output logic [WID_PE_BITS-1:0]      m0_w_data,
    output logic [N_BUF-1:0]            m1_r_en,
    output logic [N_BUF*ADDR_RAM-1:0]   m1_r_addr
);

    localparam int BW = $clog2(N_BUF) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SWITCH,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state, state_next;
    logic [ADDR_RAM:0]   len_q;
    logic [BW-1:0]       banks_q;
    logic [BW-1:0]       bank;
    logic [ADDR_RAM-1:0] addr;
    logic [ADDR_RAM-1:0] rd_addr;
    logic [ADDR_RAM-1:0] last_addr;
    logic                last_bank;
    logic [BW-1:0]       banks_clamped;
    logic [N_BUF-1:0]    bank_mask;
    logic                wr;
    logic                rd;

    // len is at least 1 whenever the counters run, so len-1 always fits ADDR_RAM bits
    assign last_addr = ADDR_RAM'(len_q - 1'b1);
    assign last_bank = (bank == banks_q - 1'b1);

    assign busy      = (state != S_IDLE);
    assign m0_w_addr = addr;
    assign m0_w_data = in_data;
    assign m1_r_addr = {N_BUF{rd_addr}};

    always_comb begin
        banks_clamped = cfg_banks;
        if (cfg_banks == '0 || cfg_banks > BW'(N_BUF)) begin
            banks_clamped = BW'(N_BUF);
        end
    end

    always_comb begin
        bank_mask = '0;
        for (int i = 0; i < N_BUF; i++) begin
            bank_mask[i] = (i < int'(banks_q));
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        m0_w_en    = '0;
        m1_r_en    = '0;
        mode       = 1'b0;
        done       = 1'b0;
        wr         = 1'b0;
        rd         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (cfg_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = !rst;
                wr       = in_valid && !rst;
                if (wr) begin
                    m0_w_en = N_BUF'(1) << bank;
                    if (addr == last_addr && last_bank) begin
                        state_next = S_SWITCH;
                    end
                end
            end
            S_SWITCH: begin
                mode       = 1'b1;
                state_next = S_DRAIN;
            end
            S_DRAIN: begin
                mode = 1'b1;
                rd   = drain_ready && !rst;
                if (rd) begin
                    m1_r_en = bank_mask;
                    if (rd_addr == last_addr) begin
                        state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // lets the final read's data reach the bus before signalling done
                mode       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            banks_q   <= '0;
            bank      <= '0;
            addr      <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= |m1_r_en;
            if (state == S_IDLE && start) begin
                len_q   <= cfg_len;
                banks_q <= banks_clamped;
                bank    <= '0;
                addr    <= '0;
            end
            if (wr) begin
                if (addr == last_addr) begin
                    addr <= '0;
                    bank <= last_bank ? '0 : bank + 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
            if (state == S_SWITCH) begin
                rd_addr <= '0;
            end
            if (rd) begin
                rd_addr <= (rd_addr == last_addr) ? '0 : rd_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_sequencer.sv
// tb/tb_buffer_sequencer.sv - self-checking bench for buffer_sequencer
module tb_buffer_sequencer;

    localparam int NB = 4;
    localparam int AR = 3;
    localparam int W  = 16;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_SWITCH = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_FLUSH  = 4;
    localparam int P_DONE   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AR:0]       cfg_len = '0;
    logic [2:0]        cfg_banks = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic              drain_ready = 1'b1;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              mode;
    logic [NB-1:0]     m0_w_en;
    logic [AR-1:0]     m0_w_addr;
    logic [W-1:0]      m0_w_data;
    logic [NB-1:0]     m1_r_en;
    logic [NB*AR-1:0]  m1_r_addr;

    buffer_sequencer #(.N_BUF(NB), .ADDR_RAM(AR), .WID_PE_BITS(W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_banks(cfg_banks),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .drain_ready(drain_ready), .out_valid(out_valid), .busy(busy), .done(done),
        .mode(mode), .m0_w_en(m0_w_en), .m0_w_addr(m0_w_addr), .m0_w_data(m0_w_data),
        .m1_r_en(m1_r_en), .m1_r_addr(m1_r_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // pass model: phase follows from how many words/reads the pass has seen so far
    bit  m_act = 1'b0;
    int  m_len = 0, m_banks = 0, m_w = 0, m_r = 0;
    bit  m_sw = 1'b0, m_fl = 1'b0, exp_ov = 1'b0;
    int  cyc = 0, start_cyc = 0, done_cyc = 0;

    logic [NB-1:0] acc_wen, acc_ren;
    bit            acc_inr;
    int            n_w, n_done;
    int            rd_addr_q[$], rd_cyc_q[$], ov_cyc_q[$];
    logic [W-1:0]  ov_q[$];
    logic [6:0]    w_log[$];
    logic [W-1:0]  bmem[NB][1<<AR];
    logic [W-1:0]  bus[NB];

    function automatic int phase();
        if (!m_act) return P_IDLE;
        if (m_len == 0) return P_DONE;
        if (m_w < m_len * m_banks) return P_LOAD;
        if (!m_sw) return P_SWITCH;
        if (m_r < m_len) return P_DRAIN;
        if (!m_fl) return P_FLUSH;
        return P_DONE;
    endfunction

    always @(negedge clk) begin : compare
        int ph;
        logic [NB-1:0] e_wen, e_ren;
        cyc++;
        ph = phase();
        e_wen = '0;
        e_ren = '0;
        if (ph == P_LOAD && !rst && in_valid) e_wen = NB'(1 << (m_w / m_len));
        if (ph == P_DRAIN && !rst && drain_ready) e_ren = NB'((1 << m_banks) - 1);
        chk("busy", busy, ph != P_IDLE);
        chk("mode", mode, ph == P_SWITCH || ph == P_DRAIN || ph == P_FLUSH);
        chk("done", done, ph == P_DONE);
        chk("in_ready", in_ready, ph == P_LOAD && !rst);
        chk("m0_w_en", m0_w_en, e_wen);
        chk("m1_r_en", m1_r_en, e_ren);
        chk("out_valid", out_valid, exp_ov);
        if (e_wen != '0) begin
            chk("m0_w_addr", m0_w_addr, m_w % m_len);
            chk("m0_w_data", m0_w_data, in_data);
        end
        if (e_ren != '0) begin
            for (int b = 0; b < NB; b++) chk("m1_r_addr", m1_r_addr[b*AR +: AR], m_r);
        end

        // emulated buffer with one-cycle read latency, plus run statistics
        if (out_valid) begin
            for (int b = 0; b < NB; b++) ov_q.push_back(bus[b]);
            ov_cyc_q.push_back(cyc);
        end
        for (int b = 0; b < NB; b++) begin
            if (m1_r_en[b]) bus[b] = bmem[b][m1_r_addr[b*AR +: AR]];
            if (m0_w_en[b]) bmem[b][m0_w_addr] = m0_w_data;
        end
        if (m1_r_en != '0) begin
            rd_addr_q.push_back(int'(m1_r_addr[AR-1:0]));
            rd_cyc_q.push_back(cyc);
        end
        if (m0_w_en != '0) begin
            w_log.push_back({m0_w_en, m0_w_addr});
            n_w++;
        end
        acc_wen |= m0_w_en;
        acc_ren |= m1_r_en;
        acc_inr |= in_ready;
        if (done) n_done++;

        exp_ov = (e_ren != '0);
        if (rst) begin
            m_act = 1'b0;
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    m_act   = 1'b1;
                    m_len   = int'(cfg_len);
                    m_banks = (cfg_banks == 0 || cfg_banks > NB) ? NB : int'(cfg_banks);
                    m_w = 0; m_r = 0; m_sw = 1'b0; m_fl = 1'b0;
                    start_cyc = cyc;
                end
                P_LOAD:   if (in_valid) m_w++;
                P_SWITCH: m_sw = 1'b1;
                P_DRAIN:  if (drain_ready) m_r++;
                P_FLUSH:  m_fl = 1'b1;
                default: begin
                    m_act    = 1'b0;
                    done_cyc = cyc;
                end
            endcase
        end
    end

    task automatic clear_acc();
        acc_wen = '0; acc_ren = '0; acc_inr = 1'b0; n_w = 0; n_done = 0;
        rd_addr_q.delete(); rd_cyc_q.delete(); ov_cyc_q.delete(); ov_q.delete(); w_log.delete();
    endtask

    task automatic pulse_start(input int len, input int banks);
        cfg_len   = (AR+1)'(len);
        cfg_banks = 3'(banks);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // streams words 0,1,2,... until the DUT reaches the turnaround cycle
    task automatic feed(input bit gaps);
        int  word = 0;
        bit  reached = 1'b0;
        for (int it = 0; it < 300; it++) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = W'(word);
            @(negedge clk);
            if (mode) begin
                reached = 1'b1;
                break;
            end
            if (in_valid && in_ready) word++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("feed_timeout", reached, 1'b1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", seen, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mode", mode, 1'b0);
        @(posedge clk); #1;

        // full 4x3 pass, continuous stream
        clear_acc();
        pulse_start(3, 4);
        feed(1'b0);
        wait_done();
        chk("t1_cycles", done_cyc - start_cyc, 18);
        chk("t1_ndone", n_done, 1);
        chk("t1_nw", n_w, 12);
        chk("t1_ren", acc_ren, 4'hF);
        chk("t1_ov_count", ov_q.size(), 12);
        if (ov_q.size() == 12) begin
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < NB; b++) chk("t1_lane", ov_q[a*NB+b], 3*b + a);
        end
        chk("t1_rd_count", rd_addr_q.size(), 3);
        if (rd_addr_q.size() == 3) for (int a = 0; a < 3; a++) chk("t1_rd_addr", rd_addr_q[a], a);

        // two banks, gappy stream
        clear_acc();
        pulse_start(2, 2);
        feed(1'b1);
        wait_done();
        chk("t2_nw", n_w, 4);
        chk("t2_wen", acc_wen, 4'b0011);
        chk("t2_ren", acc_ren, 4'b0011);
        chk("t2_ndone", n_done, 1);

        // drain backpressure 1,0,0,1,1
        clear_acc();
        drain_ready = 1'b0;
        pulse_start(3, 2);
        feed(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drain_ready = pat[i];
        end
        drain_ready = 1'b1;
        wait_done();
        chk("t3_rd_count", rd_addr_q.size(), 3);
        chk("t3_ov_count", ov_cyc_q.size(), 3);
        if (rd_addr_q.size() == 3 && ov_cyc_q.size() == 3) begin
            for (int a = 0; a < 3; a++) begin
                chk("t3_rd_addr", rd_addr_q[a], a);
                chk("t3_ov_lag", ov_cyc_q[a] - rd_cyc_q[a], 1);
            end
            chk("t3_gap0", rd_cyc_q[1] - rd_cyc_q[0], 3);
            chk("t3_gap1", rd_cyc_q[2] - rd_cyc_q[1], 1);
        end

        // zero-length pass
        clear_acc();
        pulse_start(0, 4);
        @(negedge clk);
        chk("t4_busy1", busy, 1'b1);
        chk("t4_done1", done, 1'b1);
        @(negedge clk);
        chk("t4_busy2", busy, 1'b0);
        chk("t4_done2", done, 1'b0);
        @(posedge clk); #1;
        chk("t4_inr", acc_inr, 1'b0);
        chk("t4_wen", acc_wen, 4'b0);
        chk("t4_ren", acc_ren, 4'b0);
        chk("t4_ndone", n_done, 1);

        // reset in the middle of LOAD
        clear_acc();
        in_valid = 1'b1;
        in_data  = 16'h0055;
        pulse_start(3, 4);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_inr_in_rst", in_ready, 1'b0);
        chk("t5_wen_in_rst", m0_w_en, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_done", done, 1'b0);
        @(posedge clk); #1;
        chk("t5_nw", n_w, 5);
        chk("t5_ndone", n_done, 0);
        clear_acc();
        pulse_start(3, 4);
        feed(1'b0);
        wait_done();
        chk("t5_first_write", (w_log.size() > 0) ? w_log[0] : 7'h7F, {4'b0001, 3'd0});
        chk("t5_nw_fresh", n_w, 12);
        chk("t5_ndone_fresh", n_done, 1);

        // start during DRAIN is ignored
        clear_acc();
        pulse_start(2, 3);
        feed(1'b0);
        @(posedge clk); #1;
        cfg_len = 4'd5; cfg_banks = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        chk("t6_ndone", n_done, 1);
        chk("t6_nw", n_w, 6);
        chk("t6_rd_count", rd_addr_q.size(), 2);
        chk("t6_ren", acc_ren, 4'b0111);
        clear_acc();
        pulse_start(1, 1);
        feed(1'b0);
        wait_done();
        chk("t6_next_nw", n_w, 1);
        chk("t6_next_wen", acc_wen, 4'b0001);
        chk("t6_next_ndone", n_done, 1);

        // full address range, banks=0 clamps to all banks
        clear_acc();
        pulse_start(8, 0);
        feed(1'b1);
        wait_done();
        chk("t7_nw", n_w, 32);
        chk("t7_ren", acc_ren, 4'hF);
        chk("t7_rd_count", rd_addr_q.size(), 8);
        if (rd_addr_q.size() == 8) chk("t7_last_rd", rd_addr_q[7], 7);

        // banks beyond N_BUF clamp
        clear_acc();
        pulse_start(1, 7);
        feed(1'b0);
        wait_done();
        chk("t8_nw", n_w, 4);
        chk("t8_wen", acc_wen, 4'hF);
        chk("t8_rd_count", rd_addr_q.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffer_sequencer.md
Name: buffer_sequencer

Overview:
- Controller that sequences the N_BUF-bank activation buffer through one load/drain pass.
- LOAD phase: accepts a serial word stream and writes it bank-by-bank using the buffer's mode 0 (serial) port.
- DRAIN phase: switches the buffer to mode 1 (parallel) and reads all used banks in lockstep, one address per cycle, into the PE array.
- Sits between the DMA/stream front-end, the memory buffer, and the PE array feeder.

Parameters:
- N_BUF, 8, number of memory banks in the buffer
- ADDR_RAM, 10, bank address width
- WID_PE_BITS, 16, data word width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; latches config and begins a pass (ignored unless IDLE)
- cfg_len  in  ADDR_RAM+1  words per bank (0..2^ADDR_RAM)
- cfg_banks  in  $clog2(N_BUF)+1  banks used (1..N_BUF)
- in_valid  in  1  stream word valid
- in_ready  out  1  stream ready
- in_data  in  WID_PE_BITS  stream word
- drain_ready  in  1  PE feeder can take a parallel vector
- out_valid  out  1  m1_output_bus holds a valid vector this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of pass
- mode  out  1  buffer mode select (0 serial, 1 parallel)
- m0_w_en  out  N_BUF  one-hot serial write enable
- m0_w_addr  out  ADDR_RAM  serial write address
- m0_w_data  out  WID_PE_BITS  serial write data
- m1_r_en  out  N_BUF  parallel read enables
- m1_r_addr  out  N_BUF*ADDR_RAM  packed parallel read addresses (all lanes equal)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - state=IDLE; all counters 0; out_valid=0, done=0, mode=0.
  - While rst is high, in_ready, m0_w_en and m1_r_en are forced to 0 combinationally, including when rst is asserted mid-pass.
  - A pass interrupted by reset is abandoned; no done pulse is produced.
- Memory bank read latency is 1 cycle: data for an m1_r_en issued in cycle t is on the bus in cycle t+1.
- States: IDLE, LOAD, SWITCH, DRAIN, FLUSH, DONE.
- IDLE:
  - mode=0, in_ready=0.
  - start latches cfg_len/cfg_banks.
  - cfg_len==0 -> DONE; cfg_banks==0 or cfg_banks>N_BUF clamps to N_BUF; otherwise -> LOAD.
- LOAD:
  - mode=0, in_ready=1.
  - On in_valid&in_ready: m0_w_en=onehot(bank), m0_w_addr=addr, m0_w_data=in_data, all combinational in the same cycle.
  - Counter update: addr++; when addr==len-1, addr<=0 and bank++.
  - Write with bank==banks-1 and addr==len-1 -> SWITCH.
  - in_valid low: no write, counters hold.
- SWITCH:
  - One turnaround cycle; mode=1; no enables.
  - rd_addr<=0 -> DRAIN.
- DRAIN:
  - mode=1.
  - When drain_ready: m1_r_en = low cfg_banks bits set; every m1_r_addr lane = rd_addr; rd_addr++.
  - Read issued at rd_addr==len-1 -> FLUSH.
  - drain_ready low: no read, rd_addr holds.
- FLUSH:
  - mode=1; no enables.
  - Waits one cycle so the last out_valid appears -> DONE.
- DONE:
  - done=1 for one cycle; mode=0 -> IDLE.
- out_valid is registered: it equals "m1_r_en != 0" from the previous cycle. The consumer must accept every vector; there is no output stall.
- Unused banks (index >= cfg_banks) never see write or read enables.
- busy = (state != IDLE), DONE included.
- start outside IDLE is ignored.
- Counters never exceed the configured bounds. With len = 2^ADDR_RAM, addr wraps from max to 0 exactly at the bank change.

Test Plan:
- N_BUF=4, cfg_len=3, cfg_banks=4, in_valid held high, words 0..11 -> m0_w_en=0001 for addr 0,1,2, then 0010, 0100, 1000. Bank b addr a holds word 3b+a. SWITCH 1 cycle; 3 reads at addr 0,1,2 with m1_r_en=1111; out_valid in 3 consecutive cycles with lane b = 3b+{0,1,2}; done pulses once; 12+1+3+1+1 cycles after start.
- cfg_banks=2, cfg_len=2, random in_valid gaps -> exactly 4 writes, only m0_w_en bits 0/1 ever set. m1_r_en=0011. Lanes 2/3 never enabled.
- DRAIN with drain_ready toggling 1,0,0,1,1 (len=3) -> reads at addr 0,1,2 only in drain_ready cycles. out_valid one cycle after each read; no repeated or skipped address.
- cfg_len=0, start -> busy for one cycle, done=1 in the next cycle; no in_ready and no enables ever asserted.
- rst asserted in LOAD after 5 writes -> same cycle: in_ready=0, m0_w_en=0. Next cycle: IDLE, out_valid=0, no done. A fresh start then writes from bank 0 addr 0.
- start pulsed again during DRAIN -> ignored; pass completes with a single done pulse, and a later start begins a new pass normally.
